// File: rtl/keypad_pkg.sv
// Shared types for the decimal keypad front-end: key vector type,
// debouncer FSM states and a one-hot test helper.
package keypad_pkg;

   localparam int NUM_KEYS = 10;

   typedef logic [NUM_KEYS-1:0] key_vec_t;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } kd_state_t;

   // True when exactly one key line is set.
   function automatic logic is_onehot(key_vec_t v);
      int unsigned ones;
      ones = 0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         ones += {31'd0, v[i]};
      end
      return (ones == 1);
   endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchroniser for a bus of asynchronous, independent lines.
// Each bit is synchronised on its own; no cross-bit coherency is implied.
module key_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_d, meta_q;
   logic [W-1:0] sync_d, sync_q;

   // Next values simply shift the chain by one stage.
   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   // Chain registers, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/decimal_key_debouncer.sv
// Decimal keypad front-end: synchronises ten raw key lines, debounces
// press and release, and presents a held one-hot code for a downstream
// BCD encoder with a one-cycle strobe per accepted press. Multi-key
// presses raise an error strobe and never reach key_onehot.
// Optional build macro KEY_REPEAT_EN adds auto-repeat of key_valid while
// an accepted key stays held.
module decimal_key_debouncer
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_raw,
   output logic [NUM_KEYS-1:0] key_onehot,
   output logic                key_valid,
   output logic                key_error,
   output logic                busy
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // A counter that accepts on its first sample would make the filter
   // transparent, and a repeat period below two cycles is meaningless.
   if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
      $error("decimal_key_debouncer: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   key_vec_t   s;

   kd_state_t  state_d, state_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;
   key_vec_t   sample_d, sample_q;
   key_vec_t   key_onehot_d, key_onehot_q;
   logic       key_valid_d, key_valid_q;
   logic       key_error_d, key_error_q;

`ifdef KEY_REPEAT_EN
   localparam int               REP_W    = $clog2(REPEAT_CYCLES);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

   logic [REP_W-1:0] rep_cnt_d, rep_cnt_q;
   // Set only when the press that led into HELD was a legal single key.
   logic             rep_ok_d, rep_ok_q;
`endif

   key_sync #(
      .W (NUM_KEYS)
   ) u_key_sync (
      .clk (clk),
      .rst (rst),
      .d   (key_raw),
      .q   (s)
   );

   // Next-state, counter and strobe logic; strobes default low so they
   // last exactly one cycle.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sample_d     = sample_q;
      key_onehot_d = key_onehot_q;
      key_valid_d  = 1'b0;
      key_error_d  = 1'b0;
`ifdef KEY_REPEAT_EN
      rep_cnt_d    = rep_cnt_q;
      rep_ok_d     = rep_ok_q;
`endif

      case (state_q)
         IDLE: begin
            if (s != '0) begin
               sample_d = s;
               cnt_d    = CNT_ONE;
               state_d  = DEBOUNCE;
            end
         end

         DEBOUNCE: begin
            if (s == '0) begin
               // Short glitch: drop it without any strobe.
               state_d = IDLE;
            end else if (s != sample_q) begin
               // Pattern still settling: restart on the new pattern.
               sample_d = s;
               cnt_d    = CNT_ONE;
            end else if (cnt_q == CNT_LAST) begin
               if (is_onehot(sample_q)) begin
                  key_onehot_d = sample_q;
                  key_valid_d  = 1'b1;
`ifdef KEY_REPEAT_EN
                  rep_ok_d     = 1'b1;
`endif
               end else begin
                  key_error_d  = 1'b1;
`ifdef KEY_REPEAT_EN
                  rep_ok_d     = 1'b0;
`endif
               end
`ifdef KEY_REPEAT_EN
               rep_cnt_d = '0;
`endif
               state_d = HELD;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         HELD: begin
            if (s == '0) begin
               cnt_d   = CNT_ONE;
               state_d = RELEASE;
            end
`ifdef KEY_REPEAT_EN
            else if (rep_ok_q && (s == key_onehot_q)) begin
               if (rep_cnt_q == REP_LAST) begin
                  key_valid_d = 1'b1;
                  rep_cnt_d   = '0;
               end else begin
                  rep_cnt_d   = rep_cnt_q + REP_W'(1);
               end
            end else begin
               // Different or extra key held: restart the repeat period.
               rep_cnt_d = '0;
            end
`endif
         end

         RELEASE: begin
            if (s != '0) begin
               // Release bounce: the key is still considered held.
               state_d = HELD;
`ifdef KEY_REPEAT_EN
               rep_cnt_d = '0;
`endif
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and output registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         sample_q     <= '0;
         key_onehot_q <= '0;
         key_valid_q  <= 1'b0;
         key_error_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sample_q     <= sample_d;
         key_onehot_q <= key_onehot_d;
         key_valid_q  <= key_valid_d;
         key_error_q  <= key_error_d;
      end
   end

`ifdef KEY_REPEAT_EN
   // Auto-repeat period counter and eligibility flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt_q <= '0;
         rep_ok_q  <= 1'b0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         rep_ok_q  <= rep_ok_d;
      end
   end
`endif

   assign key_onehot = key_onehot_q;
   assign key_valid  = key_valid_q;
   assign key_error  = key_error_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Directed bench for decimal_key_debouncer: reset abort, clean press,
// restart, bounce, multi-key, key sweep and hold (auto-repeat aware).
module tb_decimal_key_debouncer;

   logic       clk;
   logic       rst;
   logic [9:0] key_raw;
   logic [9:0] key_onehot;
   logic       key_valid;
   logic       key_error;
   logic       busy;

   int n_assert;
   int n_fail;
   int tick_no;
   int nv, ne, first_v, first_e, both, bad_oh;

   decimal_key_debouncer #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_CYCLES   (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_raw    (key_raw),
      .key_onehot (key_onehot),
      .key_valid  (key_valid),
      .key_error  (key_error),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr;
      nv = 0; ne = 0; first_v = 0; first_e = 0; tick_no = 0;
   endtask

   // Drive k for n cycles, sampling outputs 1 time unit after each edge.
   task automatic run(input logic [9:0] k, input int n);
      key_raw = k;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         tick_no++;
         if (key_valid) begin
            nv++;
            if (first_v == 0) first_v = tick_no;
         end
         if (key_error) begin
            ne++;
            if (first_e == 0) first_e = tick_no;
         end
         if (key_valid && key_error) both++;
         if ($countones(key_onehot) > 1) bad_oh++;
      end
   endtask

   // Reference BCD encoder: index of the set bit, 15 when none set.
   function automatic int enc(input logic [9:0] v);
      int r;
      r = 15;
      for (int i = 0; i < 10; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      n_assert = 0; n_fail = 0; both = 0; bad_oh = 0;
      rst = 1'b1;
      key_raw = '0;
      clr();

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_onehot", 32'(key_onehot), 32'd0);
      check("rst_valid",  32'(key_valid),  32'd0);
      check("rst_error",  32'(key_error),  32'd0);
      check("rst_busy",   32'(busy),       32'd0);
      rst = 1'b0;

      // Abort a debounce with asynchronous reset
      clr();
      run(10'd4, 4);
      check("abort_busy_before", 32'(busy), 32'd1);
      check("abort_no_valid",    32'(nv),   32'd0);
      #2 rst = 1'b1;
      #1;
      check("abort_async_busy",   32'(busy),       32'd0);
      check("abort_async_onehot", 32'(key_onehot), 32'd0);
      check("abort_async_valid",  32'(key_valid),  32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clr();
      run(10'd4, 10);
      check("abort_fresh_nv",    32'(nv),         32'd1);
      check("abort_fresh_tick",  32'(first_v),    32'd6);
      check("abort_fresh_oh",    32'(key_onehot), 32'd4);
      clr();
      run(10'd0, 10);
      check("abort_rel_busy",    32'(busy),       32'd0);

      // Clean press of key 0
      clr();
      run(10'd1, 20);
      check("clean_nv",     32'(nv),      32'd1);
      check("clean_tick",   32'(first_v), 32'd6);
      check("clean_ne",     32'(ne),      32'd0);
      check("clean_busy",   32'(busy),    32'd1);
      clr();
      run(10'd0, 10);
      check("clean_rel_oh",   32'(key_onehot), 32'd1);
      check("clean_rel_busy", 32'(busy),       32'd0);
      check("clean_rel_nv",   32'(nv),         32'd0);

      // Pattern change mid-debounce restarts the count
      clr();
      run(10'd16, 2);
      run(10'd32, 12);
      check("restart_nv",   32'(nv),         32'd1);
      check("restart_tick", 32'(first_v),    32'd8);
      check("restart_oh",   32'(key_onehot), 32'd32);
      run(10'd0, 10);

      // Bounce on key 3 then stable
      clr();
      for (int i = 0; i < 3; i++) begin
         run(10'd8, 1);
         run(10'd0, 1);
      end
      run(10'd8, 20);
      check("bounce_nv",   32'(nv),         32'd1);
      check("bounce_tick", 32'(first_v),    32'd12);
      check("bounce_oh",   32'(key_onehot), 32'd8);
      run(10'd0, 10);

      // Multi-key press rejected
      clr();
      run(10'd3, 10);
      check("multi_ne",   32'(ne),         32'd1);
      check("multi_tick", 32'(first_e),    32'd6);
      check("multi_nv",   32'(nv),         32'd0);
      check("multi_oh",   32'(key_onehot), 32'd8);
      run(10'd0, 10);
      check("multi_rel_busy", 32'(busy),   32'd0);

      // Sweep all ten keys
      for (int k = 0; k < 10; k++) begin
         clr();
         run(10'd1 << k, 10);
         check("sweep_nv",  32'(nv),              32'd1);
         check("sweep_oh",  32'(key_onehot),      32'd1 << k);
         check("sweep_bcd", 32'(enc(key_onehot)), 32'(k));
         run(10'd0, 10);
      end

      // Long hold of key 9
      clr();
      run(10'd512, 60);
`ifdef KEY_REPEAT_EN
      check("hold_nv", 32'(nv), 32'd4);
`else
      check("hold_nv", 32'(nv), 32'd1);
`endif
      check("hold_first", 32'(first_v), 32'd6);
      run(10'd0, 10);

      check("never_both",     32'(both),   32'd0);
      check("onehot_legal",   32'(bad_oh), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/decimal_key_debouncer.md
Name: decimal_key_debouncer

Overview:
- Upstream front-end for bcd_encoder. Takes 10 raw, bouncy, asynchronous decimal key lines and synchronises and debounces them.
- Validates that exactly one key is pressed, then presents a clean held one-hot word on key_onehot (drives bcd_encoder y) plus a one-cycle key_valid strobe per accepted press.
- Multi-key presses are rejected with an error strobe, so the encoder only ever sees legal one-hot codes.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to accept a press or a release (min 2).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived; not overridden).
- REPEAT_CYCLES, 16, auto-repeat period in cycles (used only with KEY_REPEAT_EN).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_raw  input  10  raw key lines; bit k = decimal key k, 1 = pressed; asynchronous to clk.
- key_onehot  output  10  last accepted key, one-hot; held until the next accepted press.
- key_valid  output  1  one-cycle strobe on acceptance of a debounced single-key press.
- key_error  output  1  one-cycle strobe when a debounced sample has more than one bit set.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset: one clock, asynchronous, active-high. While rst=1:
  - key_onehot=0, key_valid=0, key_error=0, busy=0.
  - Synchroniser flops=0, counter=0, state=IDLE.
- Reset mid-operation aborts any debounce with no strobe.
- Synchroniser: 2-flop chain per bit; s = second stage. All decisions use s only.
- FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
- IDLE:
  - s==0: stay.
  - s!=0: capture sample<=s, cnt<=1, go DEBOUNCE.
- DEBOUNCE:
  - s==sample and cnt<DEBOUNCE_CYCLES-1: cnt++.
  - s==sample and cnt==DEBOUNCE_CYCLES-1: accept.
    - If sample is one-hot: key_onehot<=sample, key_valid<=1 for exactly one cycle.
    - Otherwise: key_error<=1 for one cycle; key_onehot unchanged.
    - Either way, go HELD.
  - s!=sample and s!=0: sample<=s, cnt<=1 (restart).
  - s==0: go IDLE, no strobe (glitch rejected).
- HELD:
  - Wait while s!=0. A change of pressed key while held does not re-trigger.
  - s==0: cnt<=1, go RELEASE.
- RELEASE:
  - s==0: cnt++; on cnt==DEBOUNCE_CYCLES-1 go IDLE.
  - s!=0: go HELD (bounce on release).
- Latency: key_raw stable from before edge 1 → s valid after edge 2 → DEBOUNCE entered at edge 3. key_valid is high in the cycle after edge DEBOUNCE_CYCLES+2 (edge 6 for default 4). That is, key_valid is registered at edge 6.
- Strobes are registered and cleared on the following edge. key_valid and key_error are never high together.
- key_onehot is always 0 or exactly one-hot. It never takes a multi-bit value.
- Simultaneous press of two keys within one synchronised sample counts as multi-key → key_error.
- busy = (state != IDLE).

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In HELD with an accepted one-hot key, a repeat counter runs.
  - Every REPEAT_CYCLES cycles while s==key_onehot, key_valid pulses one cycle.
  - The repeat counter is cleared on entry to HELD and on any s change.
  - No repeat after a key_error press.
- Undefined: no repeat logic is present. HELD emits no strobes.

Decomposition:
- Package keypad_pkg holds:
  - NUM_KEYS=10.
  - Typedef key_vec_t = logic [NUM_KEYS-1:0].
  - State enum kd_state_t {IDLE, DEBOUNCE, HELD, RELEASE}.
  - One-hot check function is_onehot(key_vec_t), true when popcount==1.
- Sub-module key_sync: parameterised-width 2-flop synchroniser with async active-high reset to 0. It is instantiated once for the 10-bit bus.

Test Plan:
- Reset: assert rst mid-DEBOUNCE with key_raw=10'd4 → all outputs 0 immediately (asynchronous), no key_valid after release of rst until a fresh full debounce.
- Clean press: key_raw=10'd1 held 20 cycles → key_valid single pulse registered at edge 6; key_onehot=10'b0000000001 held after release; busy returns 0 after release debounce.
- Bounce: key_raw toggles 10'd8/0 every cycle for 6 cycles, then stable 10'd8 → exactly one key_valid, 4 stable samples after bounce ends; key_onehot=10'd8.
- Multi-key: key_raw=10'd3 (keys 0 and 1) held 10 cycles → key_error one pulse, key_valid never, key_onehot keeps previous value 10'd8.
- Sweep: keys 10'd1,2,4,...,512 each pressed 10 cycles and released 10 cycles → ten key_valid pulses; key_onehot matches each; downstream bcd_encoder a = 0..9 in order.
- KEY_REPEAT_EN: hold 10'd512 for 60 cycles → initial key_valid plus a repeat pulse every 16 cycles (3 repeats); without the macro → one pulse only.
